btn_strobe_gen: RTL
===================

// Module: btn_strobe_gen
// PURPOSE
//  Conditions the four raw player push-buttons and produces the one-cycle move
//  strobes ply1_up/ply1_down/ply2_up/ply2_down consumed by the paddle position
//  controller. Each button is synchronised, debounced and fed to a per-button
//  press/auto-repeat FSM, so one press moves a paddle once and a held button
//  repeats at a fixed tick rate. Sits between the board pins and the paddle controller.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive clk cycles a new level must persist (>=1)
//  TICK_DIV         200000  repeat period in clk cycles (>=2)
//  REPEAT_DELAY     3       ticks a button is held before auto-repeat starts (>=0)
//  ACTIVE_LOW       0       1: btn_raw pins read 0 when pressed
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  btn_raw    in   4  raw pins: [0]=ply1 up, [1]=ply1 down, [2]=ply2 up, [3]=ply2 down
//  ply1_up    out  1  1-cycle move strobe, player 1 up
//  ply1_down  out  1  1-cycle move strobe, player 1 down
//  ply2_up    out  1  1-cycle move strobe, player 2 up
//  ply2_down  out  1  1-cycle move strobe, player 2 down
//  btn_state  out  4  debounced pressed levels, same bit order as btn_raw
// BEHAVIOUR
//  Reset: all outputs, sync FFs, debounce counters, tick prescaler, FSMs -> 0/IDLE.
//   Outputs go 0 immediately on rst_n fall; logic resumes on first edge after rise.
//  Polarity: p = btn_raw ^ {4{ACTIVE_LOW}} (1 = pressed) before synchroniser.
//  Sync: 2-FF synchroniser per bit, reset value 0 (released).
//  Debounce per bit: counter cnt (width clog2(DEBOUNCE_CYCLES+1)).
//   - sync == btn_state: cnt <= 0.
//   - sync != btn_state: cnt++; when cnt == DEBOUNCE_CYCLES-1, btn_state <= sync, cnt <= 0.
//   - Any bounce back to btn_state level restarts the count; counter never wraps.
//  Tick: free-running prescaler 0..TICK_DIV-1, tick=1 for one cycle at TICK_DIV-1.
//   Shared by all four FSMs; not re-aligned by button presses.
//  Per-button FSM (registered pulse `rq`):
//   - IDLE: btn_state=1 -> rq=1 for one cycle, go HOLD with hcnt=0.
//     If REPEAT_DELAY==0 go to REPEAT instead.
//   - HOLD: on tick, hcnt++. When hcnt reaches REPEAT_DELAY (on that tick) go REPEAT; no pulse.
//   - REPEAT: rq=1 on every tick cycle.
//   - Any state with btn_state=0 -> IDLE next cycle, no pulse that cycle.
//  Latency: raw edge (stable) to first strobe = DEBOUNCE_CYCLES+3 clk cycles.
//   That is 2 sync + DEBOUNCE_CYCLES debounce + 1 FSM.
//  Conflict: if up and down of the same player both have btn_state=1:
//   - that player's two strobes are forced 0; FSMs keep running.
//   - releasing one re-enables the other at its next scheduled pulse.
//  Strobes are registered, never wider than 1 cycle.
//   Different players are independent and may strobe in the same cycle.
// TESTING (DEBOUNCE_CYCLES=4, TICK_DIV=8, REPEAT_DELAY=2, ACTIVE_LOW=0)
//  1. Clean press btn_raw[0] held 60 cycles:
//     ply1_up high exactly at cycle 7 after the edge; none at the next 2 ticks;
//     then one pulse per tick (8-cycle spacing). btn_state[0]=1 from cycle 6.
//  2. Bounce: btn_raw[2] toggled every 2 cycles for 30 cycles, then 0:
//     btn_state stays 0000, no strobes.
//  3. Conflict: btn_raw=0011 held 50 cycles -> btn_state=0011, ply1_up/ply1_down never high.
//     Drop bit1 -> ply1_up pulses at the next tick once btn_state[1] falls.
//  4. Release: in REPEAT, drop btn_raw[3]:
//     btn_state[3] falls 6 cycles later; no ply2_down strobe after that cycle.
//  5. Reset mid-repeat: rst_n low 3 cycles while btn_raw[0] held:
//     all outputs 0 within the reset, asynchronously; after release, ply1_up at cycle 7.
//  6. ACTIVE_LOW=1, btn_raw=1111 for 100 cycles -> no strobes, btn_state=0000.

Source files
------------

// File: rtl/btn_strobe_gen.sv
// btn_strobe_gen: conditions four raw push-buttons into debounced levels and
// one-cycle paddle move strobes (single press -> one move, hold -> auto-repeat).
// Per-button path: polarity fix -> 2-FF synchroniser -> debounce -> FSM.
// Handshake note: there is no valid/ready flow here; each strobe is a
// registered single-cycle event that the consumer must sample every cycle.
// Per-button FSM state is held in state_q[0..3] for observation in simulation.
module btn_strobe_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TICK_DIV        = 200000,
  parameter int unsigned REPEAT_DELAY    = 3,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic       ply1_up,
  output logic       ply1_down,
  output logic       ply2_up,
  output logic       ply2_down,
  output logic [3:0] btn_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [3:0]    pressed;
  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] db_cnt_q [4];
  logic [CW-1:0] db_cnt_d [4];
  logic [3:0]    btn_state_q, btn_state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_e        state_q [4];
  state_e        state_d [4];
  logic [HW-1:0] hcnt_q [4];
  logic [HW-1:0] hcnt_d [4];
  logic [3:0]    rq_q, rq_d;
  logic [3:0]    conflict;

  // Normalise so that 1 always means "pressed" before synchronising.
  assign pressed = btn_raw ^ {4{ACTIVE_LOW}};

  // Up and down of the same player held together suppresses both strobes.
  assign conflict = {{2{btn_state_q[3] & btn_state_q[2]}},
                     {2{btn_state_q[1] & btn_state_q[0]}}};

  // Shared repeat tick: one cycle high at the last prescaler count.
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Prescaler wraps 0..TICK_DIV-1 and is never realigned by presses.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES cycles; any bounce restarts.
  always_comb begin
    btn_state_d = btn_state_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != btn_state_q[i]) begin
        if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          btn_state_d[i] = sync2_q[i];
          db_cnt_d[i]    = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Press/auto-repeat FSM per button; pulse request is gated by conflict here
  // so the strobe itself leaves a flop.
  always_comb begin
    rq_d = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      if (!btn_state_q[i]) begin
        state_d[i] = ST_IDLE;
        hcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            rq_d[i]    = ~conflict[i];
            hcnt_d[i]  = '0;
            state_d[i] = (REPEAT_DELAY == 0) ? ST_REPEAT : ST_HOLD;
          end
          ST_HOLD: begin
            if (tick) begin
              hcnt_d[i] = hcnt_q[i] + HW'(1);
              if (hcnt_d[i] == HW'(REPEAT_DELAY)) begin
                state_d[i] = ST_REPEAT;
              end
            end
          end
          ST_REPEAT: begin
            rq_d[i] = tick & ~conflict[i];
          end
          default: begin
            state_d[i] = ST_IDLE;
          end
        endcase
      end
    end
  end

  // All state registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      btn_state_q <= '0;
      tick_cnt_q  <= '0;
      rq_q        <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
        state_q[i]  <= ST_IDLE;
        hcnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= pressed;
      sync2_q     <= sync1_q;
      btn_state_q <= btn_state_d;
      tick_cnt_q  <= tick_cnt_d;
      rq_q        <= rq_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        state_q[i]  <= state_d[i];
        hcnt_q[i]   <= hcnt_d[i];
      end
    end
  end

  assign ply1_up   = rq_q[0];
  assign ply1_down = rq_q[1];
  assign ply2_up   = rq_q[2];
  assign ply2_down = rq_q[3];
  assign btn_state = btn_state_q;

endmodule
